// File: rtl/puf_response_stabilizer.sv
// Re-arms the PUF NUM_SAMPLES times and majority-votes each response bit into a stable key with an instability mask.
// Latency: key_valid rises NUM_SAMPLES*(SETTLE_CYCLES+2) cycles after start is accepted.
// Backpressure: key and unstable_mask are held in DONE until key_ready; start is ignored while busy.
module puf_response_stabilizer #(
    parameter int NUM_SAMPLES   = 15,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] challenge,
    output logic       puf_enable,
    output logic [1:0] puf_control,
    input  logic [7:0] puf_response,
    output logic [7:0] key,
    output logic [7:0] unstable_mask,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       busy
);

    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] FULL        = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] HALF        = CNT_W'(NUM_SAMPLES / 2);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       sync_meta;
    logic [7:0]       sync_resp;
    logic [CNT_W-1:0] ones_cnt [8];
    logic [CNT_W-1:0] ones_nxt [8];
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] sample_nxt;
    logic [SET_W-1:0] settle_cnt;
    logic [7:0]       key_nxt;
    logic [7:0]       mask_nxt;

    // The PUF output is asynchronous to clk; only the second stage is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_resp <= '0;
        end else begin
            sync_meta <= puf_response;
            sync_resp <= sync_meta;
        end
    end

    always_comb begin
        sample_nxt = sample_cnt + 1'b1;
        key_nxt    = '0;
        mask_nxt   = '0;
        for (int i = 0; i < 8; i++) begin
            ones_nxt[i] = ones_cnt[i] + {{(CNT_W-1){1'b0}}, sync_resp[i]};
            key_nxt[i]  = (ones_nxt[i] > HALF);
            mask_nxt[i] = (ones_nxt[i] != '0) && (ones_nxt[i] != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        puf_enable = 1'b0;
        key_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ARM;
            end
            // One disabled cycle forces a fresh race on every sample.
            ARM: state_nxt = SETTLE;
            SETTLE: begin
                puf_enable = 1'b1;
                if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                puf_enable = 1'b1;
                state_nxt  = (sample_nxt == FULL) ? DONE : ARM;
            end
            DONE: begin
                key_valid = 1'b1;
                if (key_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            puf_control   <= '0;
            sample_cnt    <= '0;
            settle_cnt    <= '0;
            key           <= '0;
            unstable_mask <= '0;
            for (int i = 0; i < 8; i++) ones_cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        puf_control <= challenge;
                        sample_cnt  <= '0;
                        for (int i = 0; i < 8; i++) ones_cnt[i] <= '0;
                    end
                end
                ARM:    settle_cnt <= '0;
                SETTLE: settle_cnt <= settle_cnt + 1'b1;
                SAMPLE: begin
                    sample_cnt <= sample_nxt;
                    for (int i = 0; i < 8; i++) ones_cnt[i] <= ones_nxt[i];
                    // Vote on the final counts so key is ready the cycle DONE is entered.
                    if (sample_nxt == FULL) begin
                        key           <= key_nxt;
                        unstable_mask <= mask_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_stabilizer.sv
// Directed bench for puf_response_stabilizer: constant keys, majority boundary, backpressure, mid-run reset, busy-start.
module tb_puf_response_stabilizer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] challenge = 2'b00;
    logic       puf_enable;
    logic [1:0] puf_control;
    logic [7:0] puf_response = 8'h00;
    logic [7:0] key;
    logic [7:0] unstable_mask;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;
    int en_err;
    int hold_err;
    logic [7:0] k0, m0;

    puf_response_stabilizer #(.NUM_SAMPLES(15), .SETTLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .challenge    (challenge),
        .puf_enable   (puf_enable),
        .puf_control  (puf_control),
        .puf_response (puf_response),
        .key          (key),
        .unstable_mask(unstable_mask),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Start a run; sample k sees (pat[k] ? hi : lo). Records latency and enable-waveform errors.
    task automatic run(input logic [1:0] ch, input logic [7:0] hi, input logic [7:0] lo,
                       input logic [14:0] pat, input bit poke);
        puf_response = pat[0] ? hi : lo;
        @(negedge clk);
        start = 1'b1;
        challenge = ch;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        en_err = 0;
        while (!key_valid && lat < 200) begin
            if (lat < 90 && lat % 6 == 0) puf_response = pat[lat/6] ? hi : lo;
            if (puf_enable !== (lat % 6 != 0)) en_err++;
            if (poke && lat == 20) begin
                start = 1'b1;
                challenge = 2'b11;
            end
            if (poke && lat == 21) start = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack();
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_key_valid", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_puf_enable", puf_enable, 0);
        check("rst_key", key, 0);
        check("rst_mask", unstable_mask, 0);
        check("rst_puf_control", puf_control, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant response plus enable waveform
        run(2'b01, 8'hA5, 8'hA5, '1, 1'b0);
        check("t1_latency", lat, 90);
        check("t1_enable_wave", en_err, 0);
        check("t1_enable_done", puf_enable, 0);
        check("t1_key", key, 8'hA5);
        check("t1_mask", unstable_mask, 8'h00);
        check("t1_puf_control", puf_control, 2'b01);
        ack();
        check("t1_valid_after_ack", key_valid, 0);
        check("t1_busy_after_ack", busy, 0);
        check("t1_key_retained", key, 8'hA5);

        // bit0 high in 8 of 15 samples
        run(2'b00, 8'h01, 8'h00, 15'h5555, 1'b0);
        check("t2a_latency", lat, 90);
        check("t2a_key", key, 8'h01);
        check("t2a_mask", unstable_mask, 8'h01);

        // Backpressure with a start pulse during DONE
        k0 = key;
        m0 = unstable_mask;
        hold_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            if (key_valid !== 1'b1 || busy !== 1'b1 || puf_enable !== 1'b0 ||
                key !== k0 || unstable_mask !== m0) hold_err++;
        end
        check("t3_hold_stable", hold_err, 0);
        check("t3_valid_held", key_valid, 1);
        ack();
        check("t3_valid_after_ack", key_valid, 0);
        check("t3_busy_after_ack", busy, 0);
        check("t3_key_retained", key, 8'h01);
        check("t3_mask_retained", unstable_mask, 8'h01);
        repeat (3) @(negedge clk);
        check("t3_no_new_run", busy, 0);

        // bit0 high in 7 of 15 samples
        run(2'b00, 8'h01, 8'h00, 15'h2AAA, 1'b0);
        check("t2b_latency", lat, 90);
        check("t2b_key", key, 8'h00);
        check("t2b_mask", unstable_mask, 8'h01);
        ack();

        // Start and challenge change while busy
        run(2'b10, 8'h5A, 8'h5A, '1, 1'b1);
        check("t5_latency", lat, 90);
        check("t5_puf_control", puf_control, 2'b10);
        check("t5_key", key, 8'h5A);
        ack();

        // Reset during SETTLE of the fifth sample
        puf_response = 8'hFF;
        @(negedge clk);
        start = 1'b1;
        challenge = 2'b01;
        @(negedge clk);
        start = 1'b0;
        repeat (26) @(negedge clk);
        check("t4_in_settle", puf_enable, 1);
        check("t4_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_puf_enable", puf_enable, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_key_valid", key_valid, 0);
        check("t4_rst_key", key, 0);
        check("t4_rst_mask", unstable_mask, 0);
        check("t4_rst_puf_control", puf_control, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2'b00, 8'h3C, 8'h3C, '1, 1'b0);
        check("t4_latency", lat, 90);
        check("t4_key", key, 8'h3C);
        check("t4_mask", unstable_mask, 8'h00);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
